// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-mode timing record, sync polarity and a helper
// that turns region widths into the total count and sync window of one axis.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    int total;
    int sync_start;
    int sync_end;
  } axis_bounds_t;

  // Sync occupies [sync_start, sync_end); active is always [0, active).
  function automatic axis_bounds_t axis_bounds(input int active, input int fp,
                                               input int sync, input int bp);
    axis_bounds_t b;
    b.total      = active + fp + sync + bp;
    b.sync_start = active + fp;
    b.sync_end   = active + fp + sync;
    return b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter that advances on step and
// flags the active and sync regions of its current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);

  localparam axis_bounds_t B = axis_bounds(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST    = W'(B.total - 1);
  localparam logic [W:0]   ACT_END = (W+1)'(ACTIVE);
  localparam logic [W:0]   SYNC_LO = (W+1)'(B.sync_start);
  localparam logic [W:0]   SYNC_HI = (W+1)'(B.sync_end);

  logic         at_last;
  logic [W:0]   count_ext;

  assign at_last = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (step)
      count <= at_last ? '0 : count + W'(1);
  end

  // Compared one bit wider so a zero-width back porch cannot overflow SYNC_HI.
  assign count_ext = {1'b0, count};
  assign wrap      = step && at_last;
  assign in_active = (count_ext < ACT_END);
  assign in_sync   = (count_ext >= SYNC_LO) && (count_ext < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: request-stage position registers, a LOOKAHEAD
// deep display pipeline and the per-line / per-frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_640X480_60.h_active,
  parameter int H_FP      = VGA_640X480_60.h_fp,
  parameter int H_SYNC    = VGA_640X480_60.h_sync,
  parameter int H_BP      = VGA_640X480_60.h_bp,
  parameter int V_ACTIVE  = VGA_640X480_60.v_active,
  parameter int V_FP      = VGA_640X480_60.v_fp,
  parameter int V_SYNC    = VGA_640X480_60.v_sync,
  parameter int V_BP      = VGA_640X480_60.v_bp,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LOOKAHEAD = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W      = $clog2(H_TOTAL),
  localparam int Y_W      = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic           req_valid,
  output logic [X_W-1:0] req_x,
  output logic [Y_W-1:0] req_y,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
);

  localparam sync_pol_e H_POL = sync_pol_e'(HSYNC_POL[0]);
  localparam sync_pol_e V_POL = sync_pol_e'(VSYNC_POL[0]);
  localparam logic      H_ON  = (H_POL == SYNC_ACTIVE_HIGH);
  localparam logic      V_ON  = (V_POL == SYNC_ACTIVE_HIGH);

  // Sync flags are carried active-high internally; polarity is applied at the pins.
  typedef struct packed {
    logic           valid;
    logic           hs;
    logic           vs;
    logic           act;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_t;

  logic [X_W-1:0] hc;
  logic [Y_W-1:0] vc;
  logic           h_wrap, h_act, h_sync, v_act, v_sync;
  logic           unused_v_wrap;
  logic           adv_q;
  pix_t           req_q;
  pix_t           disp;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h_counter (
    .clk      (clk),
    .reset    (reset),
    .step     (enable),
    .count    (hc),
    .wrap     (h_wrap),
    .in_active(h_act),
    .in_sync  (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v_counter (
    .clk      (clk),
    .reset    (reset),
    .step     (h_wrap),
    .count    (vc),
    .wrap     (unused_v_wrap),
    .in_active(v_act),
    .in_sync  (v_sync)
  );

  // adv_q remembers that the last edge advanced, which qualifies every strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      adv_q <= 1'b0;
      req_q <= '0;
    end else begin
      adv_q <= enable;
      if (enable)
        req_q <= '{valid: 1'b1, hs: h_sync, vs: v_sync, act: h_act && v_act,
                   x: hc, y: vc};
    end
  end

  generate
    if (LOOKAHEAD == 0) begin : g_no_pipe
      assign disp = req_q;
    end else begin : g_pipe
      pix_t stage [LOOKAHEAD];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LOOKAHEAD; i++)
            stage[i] <= '0;
        end else if (enable) begin
          stage[0] <= req_q;
          for (int i = 1; i < LOOKAHEAD; i++)
            stage[i] <= stage[i-1];
        end
      end

      assign disp = stage[LOOKAHEAD-1];
    end
  endgenerate

  assign req_valid   = adv_q && req_q.act;
  assign req_x       = req_q.x;
  assign req_y       = req_q.y;
  assign hsync       = (disp.hs == H_ON);
  assign vsync       = (disp.vs == V_ON);
  assign active      = disp.act;
  assign x           = disp.x;
  assign y           = disp.y;
  assign line_start  = adv_q && disp.valid && (disp.x == '0);
  assign frame_start = adv_q && disp.valid && (disp.x == '0) && (disp.y == '0);

endmodule
